// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if -- keypad matrix and decoded-key signals of keypad_scanner.
//   row_in     : keypad rows, active-low, externally pulled up, asynchronous to clk
//   col_out    : column drive, active-low, exactly one bit low
//   key_code   : code of the debounced key
//   key_valid  : high while a debounced key is held
//   key_strobe : one-cycle pulse when key_valid rises
// Modports: master = scanner side, slave = keypad / consumer side.
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_strobe;

    modport master (input  row_in,
                    output col_out, key_code, key_valid, key_strobe);
    modport slave  (output row_in,
                    input  col_out, key_code, key_valid, key_strobe);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner -- 4x4 matrix keypad scanner with press/release debounce.
// Rotates an active-low column drive and samples the synchronized rows at the
// end of each column slot. A hit freezes the column and is debounced before
// being reported; release is debounced before scanning resumes.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   kp  : keypad_scanner_if.master (row_in, col_out, key_code, key_valid, key_strobe)
// Parameters:
//   SCAN_DIV        : cycles each column stays driven
//   DEBOUNCE_CYCLES : stable cycles required for press and for release
// Build option:
//   KEYPAD_GHOST_REJECT_EN : discard samples with more than one row low;
//                            otherwise the lowest low row index wins.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state;
    logic [3:0]    sync1;
    logic [3:0]    rows_s;
    logic [CW-1:0] cnt;
    logic [1:0]    col_idx;
    logic [3:0]    pat;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          key_strobe;
    logic          any_low;
    logic          sample_hit;

    assign any_low = (rows_s != 4'hF);

`ifdef KEYPAD_GHOST_REJECT_EN
    logic [3:0] low;
    logic       multi_low;
    assign low        = ~rows_s;
    // clearing the lowest set bit leaves something only if two or more were set
    assign multi_low  = |(low & (low - 4'd1));
    assign sample_hit = any_low && !multi_low;
`else
    assign sample_hit = any_low;
`endif

    // Lowest low row wins; (row,col) -> keypad legend value.
    function automatic logic [3:0] code_of(input logic [3:0] p, input logic [1:0] c);
        logic [1:0] r;
        r = !p[0] ? 2'd0 : !p[1] ? 2'd1 : !p[2] ? 2'd2 : 2'd3;
        code_of = 4'd0;
        case ({r, c})
            4'h0: code_of = 4'd1;   4'h1: code_of = 4'd2;
            4'h2: code_of = 4'd3;   4'h3: code_of = 4'd10;
            4'h4: code_of = 4'd4;   4'h5: code_of = 4'd5;
            4'h6: code_of = 4'd6;   4'h7: code_of = 4'd11;
            4'h8: code_of = 4'd7;   4'h9: code_of = 4'd8;
            4'hA: code_of = 4'd9;   4'hB: code_of = 4'd12;
            4'hC: code_of = 4'd14;  4'hD: code_of = 4'd0;
            4'hE: code_of = 4'd15;  4'hF: code_of = 4'd13;
            default: code_of = 4'd0;
        endcase
    endfunction

    // Two-flop synchronizer; idles at all-high (no key).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            sync1  <= kp.row_in;
            rows_s <= sync1;
        end
    end

    // One counter serves the scan slot, press debounce and release debounce,
    // since only one of them is ever active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SCAN;
            cnt        <= '0;
            col_idx    <= 2'd0;
            pat        <= 4'hF;
            key_code   <= 4'd0;
            key_valid  <= 1'b0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            case (state)
                SCAN: begin
                    if (cnt == SLOT_LAST) begin
                        cnt <= '0;
                        if (sample_hit) begin
                            pat   <= rows_s;
                            state <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DEBOUNCE: begin
                    // Any deviation from the latched pattern (including an
                    // extra row going low) is a bounce: resume at next column.
                    if (rows_s != pat) begin
                        state   <= SCAN;
                        cnt     <= '0;
                        col_idx <= col_idx + 2'd1;
                    end else if (cnt == DEB_LAST) begin
                        key_code   <= code_of(pat, col_idx);
                        key_valid  <= 1'b1;
                        key_strobe <= 1'b1;
                        state      <= HELD;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (rows_s == 4'hF) begin
                        state <= RELEASE;
                        cnt   <= '0;
                    end
                end
                RELEASE: begin
                    if (rows_s != 4'hF) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        key_valid <= 1'b0;
                        col_idx   <= col_idx + 2'd1;
                        state     <= SCAN;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    assign kp.col_out    = ~(4'b0001 << col_idx);
    assign kp.key_code   = key_code;
    assign kp.key_valid  = key_valid;
    assign kp.key_strobe = key_strobe;
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000; clock cycles each column stays driven.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 200000; cycles of stable contact required for press and for release.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col_out  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port key_code  output  4  code of the debounced key.
REQ-008 SHALL have port key_valid  output  1  high while a debounced key is held.
REQ-009 SHALL have port key_strobe  output  1  one-cycle pulse on the cycle key_valid rises.

Function
REQ-010 SHALL synchronize row_in through two flip-flops; all decisions use the synchronized value rows_s.
REQ-011 SHALL map (row,col) to key_code as R0: 1,2,3,A; R1: 4,5,6,B; R2: 7,8,9,C; R3: *,0,#,D, with digits = value, A=10, B=11, C=12, D=13, *=14, #=15.
REQ-012 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 SCAN: col_out SHALL rotate C0->C1->C2->C3->C0, advancing every SCAN_DIV cycles; rows_s SHALL be sampled only on the last cycle of each slot.
REQ-014 SCAN: if the sample has any bit low, SHALL latch row pattern and column, freeze col_out, enter DEBOUNCE with counter cleared.
REQ-015 DEBOUNCE: counter SHALL increment each cycle rows_s equals the latched pattern; any mismatch SHALL return to SCAN, resuming at the next column.
REQ-016 DEBOUNCE: when counter reaches DEBOUNCE_CYCLES, SHALL load key_code, assert key_valid and key_strobe in the same cycle, enter HELD.
REQ-017 HELD: key_valid SHALL stay high and key_code stable; when rows_s becomes 4'hF, SHALL enter RELEASE with counter cleared.
REQ-018 RELEASE: counter SHALL increment on each all-high cycle and SHALL clear on any low row bit (bounce), key_valid remaining high.
REQ-019 RELEASE: when counter reaches DEBOUNCE_CYCLES, SHALL deassert key_valid, advance col_out to the next column, enter SCAN.
REQ-020 key_code SHALL hold its last value after key_valid falls.
REQ-021 key_strobe SHALL never be high for two consecutive cycles; exactly one pulse per debounced press.
REQ-022 Multiple rows low in the sample: lowest row index SHALL win (unless REQ-027 applies).
REQ-023 A second key pressed while in HELD/RELEASE SHALL be ignored until return to SCAN.
REQ-024 Counters SHALL be sized $clog2(max(SCAN_DIV,DEBOUNCE_CYCLES)+1) and SHALL never wrap.

Reset
REQ-025 On rst: state SCAN, col_out=4'b1110, key_code=0, key_valid=0, key_strobe=0, counters 0, synchronizer flops 4'hF.
REQ-026 rst asserted mid-DEBOUNCE, HELD or RELEASE SHALL drop key_valid immediately; no strobe SHALL occur on deassertion.

Configuration
REQ-027 With KEYPAD_GHOST_REJECT_EN defined, a SCAN sample or DEBOUNCE cycle with more than one row bit low SHALL be discarded (SCAN continues / DEBOUNCE returns to SCAN); without it REQ-022 applies.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-028 Press key "5" (R1,C1) clean, hold 50 cycles -> key_code=5, key_valid high, single key_strobe, col_out stuck at 4'b1101 while held.
REQ-029 Press "A" (R0,C3) with 3-cycle bounce glitches during first 6 cycles -> no strobe before 8 stable cycles, then key_code=10, one strobe.
REQ-030 Release "B" (R1,C3) with a 2-cycle re-contact after 5 high cycles -> key_valid stays high until 8 consecutive high cycles, then falls, col_out=4'b1110.
REQ-031 Press "0" and "8" (R3,C1 and R2,C1) together -> without macro key_code=8; with KEYPAD_GHOST_REJECT_EN no key_valid, scanning continues.
REQ-032 Assert rst while "#" is held in HELD -> key_valid=0, col_out=4'b1110 same cycle; after release of rst with "#" still held, new debounce and one strobe with key_code=15.
